// File: rtl/rv_trace_pkg.sv
// Shared types, header field positions and helpers for the retire-record packer.
package rv_trace_pkg;

  localparam int unsigned TRACE_WORD_W       = 32;
  localparam int unsigned TRACE_SEQ_W        = 8;
  localparam int unsigned TRACE_DROP_W       = 8;
  localparam int unsigned TRACE_CNT_W        = 4;

  localparam int unsigned TRACE_HDR_SYNC_LSB = 24;
  localparam int unsigned TRACE_HDR_SEQ_LSB  = 16;
  localparam int unsigned TRACE_HDR_DROP_LSB = 8;
  localparam int unsigned TRACE_HDR_CNT_LSB  = 4;
  localparam int unsigned TRACE_HDR_MRD_BIT  = 3;
  localparam int unsigned TRACE_HDR_MWR_BIT  = 2;
  localparam int unsigned TRACE_HDR_RW_BIT   = 1;
  localparam int unsigned TRACE_HDR_DNZ_BIT  = 0;

  typedef struct packed {
    logic [TRACE_SEQ_W-1:0]  seq;
    logic [TRACE_WORD_W-1:0] pc;
    logic [TRACE_WORD_W-1:0] instr;
    logic [TRACE_WORD_W-1:0] rd_data;
    logic [TRACE_WORD_W-1:0] mem_addr;
    logic [TRACE_WORD_W-1:0] mem_data;
    logic                    reg_write;
    logic                    mem_rd;
    logic                    mem_wr;
  } trace_rec_t;

  localparam int unsigned TRACE_REC_W = $bits(trace_rec_t);

  typedef enum logic [2:0] {
    S_HDR   = 3'd0,
    S_PC    = 3'd1,
    S_INSTR = 3'd2,
    S_RD    = 3'd3,
    S_MADDR = 3'd4,
    S_MDATA = 3'd5
  } trace_state_t;

  // Number of stream words a record occupies, header included (3..6).
  function automatic logic [TRACE_CNT_W-1:0] trace_word_count(input logic reg_write,
                                                              input logic mem_any);
    return TRACE_CNT_W'(3) + TRACE_CNT_W'(reg_write) + (mem_any ? TRACE_CNT_W'(2) : TRACE_CNT_W'(0));
  endfunction

endpackage

// File: rtl/rv_trace_fifo.sv
// Generic synchronous FIFO; wrap-bit pointers, head readable combinationally.
module rv_trace_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;

  assign empty_c = (wr_ptr_q == rd_ptr_q);
  assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_c  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; overflowing pushes and underflowing pops are ignored.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push && !full_c) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop && !empty_c) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge i_clk) begin
    if (push && !full_c) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/rv_trace_packer.sv
// Retire-record packer: buffers one record per retired instruction and
// serializes it as 3..6 words on a valid/ready stream, counting drops.
module rv_trace_packer
  import rv_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter logic [7:0]  SYNC  = 8'hA5
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_retire_valid,
  input  logic [31:0] i_retire_pc,
  input  logic [31:0] i_retire_instr,
  input  logic        i_retire_reg_write,
  input  logic [31:0] i_retire_rd_data,
  input  logic        i_retire_mem_read,
  input  logic        i_retire_mem_write,
  input  logic [31:0] i_retire_mem_addr,
  input  logic [31:0] i_retire_mem_data,
  output logic        o_valid,
  output logic [31:0] o_data,
  input  logic        i_ready
);

  trace_rec_t                in_rec;
  trace_rec_t                head_rec;
  trace_state_t              state_q;
  trace_state_t              state_d;
  logic [TRACE_SEQ_W-1:0]    seq_q;
  logic [TRACE_DROP_W-1:0]   drop_cnt_q;
  logic                      fifo_full_c;
  logic                      fifo_empty_c;
  logic                      push_c;
  logic                      drop_c;
  logic                      pop_c;
  logic                      accept_c;
  logic                      hdr_accept_c;
  logic                      head_mem_any_c;
  logic [TRACE_WORD_W-1:0]   hdr_c;
  logic [TRACE_WORD_W-1:0]   word_c;

  // Record captured from the writeback stage, tagged with the pre-increment seq.
  always_comb begin
    in_rec = '{seq:       seq_q,
               pc:        i_retire_pc,
               instr:     i_retire_instr,
               rd_data:   i_retire_rd_data,
               mem_addr:  i_retire_mem_addr,
               mem_data:  i_retire_mem_data,
               reg_write: i_retire_reg_write,
               mem_rd:    i_retire_mem_read,
               mem_wr:    i_retire_mem_write};
  end

  // Fullness is taken before any same-cycle pop, so push-while-full drops.
  assign push_c = i_retire_valid && !fifo_full_c;
  assign drop_c = i_retire_valid && fifo_full_c;

  rv_trace_fifo #(
    .WIDTH (TRACE_REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .push      (push_c),
    .push_data (in_rec),
    .pop       (pop_c),
    .head_c    (head_rec),
    .full_c    (fifo_full_c),
    .empty_c   (fifo_empty_c)
  );

  assign o_valid        = !fifo_empty_c;
  assign accept_c       = o_valid && i_ready;
  assign hdr_accept_c   = accept_c && (state_q == S_HDR);
  assign head_mem_any_c = head_rec.mem_rd || head_rec.mem_wr;
  assign o_data         = o_valid ? word_c : '0;

  // Header assembly; drop count is sampled live while the header waits.
  always_comb begin
    hdr_c = '0;
    hdr_c[TRACE_HDR_SYNC_LSB +: 8]            = SYNC;
    hdr_c[TRACE_HDR_SEQ_LSB  +: TRACE_SEQ_W]  = head_rec.seq;
    hdr_c[TRACE_HDR_DROP_LSB +: TRACE_DROP_W] = drop_cnt_q;
    hdr_c[TRACE_HDR_CNT_LSB  +: TRACE_CNT_W]  = trace_word_count(head_rec.reg_write, head_mem_any_c);
    hdr_c[TRACE_HDR_MRD_BIT]                  = head_rec.mem_rd;
    hdr_c[TRACE_HDR_MWR_BIT]                  = head_rec.mem_wr;
    hdr_c[TRACE_HDR_RW_BIT]                   = head_rec.reg_write;
    hdr_c[TRACE_HDR_DNZ_BIT]                  = (drop_cnt_q != '0);
  end

  // Serializer state register.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) state_q <= S_HDR;
    else            state_q <= state_d;
  end

  // Serializer next state, word mux and pop on the record's last word.
  always_comb begin
    state_d = state_q;
    word_c  = '0;
    pop_c   = 1'b0;
    case (state_q)
      S_HDR: begin
        word_c = hdr_c;
        if (accept_c) state_d = S_PC;
      end
      S_PC: begin
        word_c = head_rec.pc;
        if (accept_c) state_d = S_INSTR;
      end
      S_INSTR: begin
        word_c = head_rec.instr;
        if (accept_c) begin
          if (head_rec.reg_write)  state_d = S_RD;
          else if (head_mem_any_c) state_d = S_MADDR;
          else begin
            state_d = S_HDR;
            pop_c   = 1'b1;
          end
        end
      end
      S_RD: begin
        word_c = head_rec.rd_data;
        if (accept_c) begin
          if (head_mem_any_c) state_d = S_MADDR;
          else begin
            state_d = S_HDR;
            pop_c   = 1'b1;
          end
        end
      end
      S_MADDR: begin
        word_c = head_rec.mem_addr;
        if (accept_c) state_d = S_MDATA;
      end
      S_MDATA: begin
        word_c = head_rec.mem_data;
        if (accept_c) begin
          state_d = S_HDR;
          pop_c   = 1'b1;
        end
      end
      default: state_d = S_HDR;
    endcase
  end

  // Sequence counter (counts every retire) and saturating drop counter.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      seq_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (i_retire_valid) seq_q <= seq_q + TRACE_SEQ_W'(1);
      if (hdr_accept_c)
        drop_cnt_q <= drop_c ? TRACE_DROP_W'(1) : TRACE_DROP_W'(0);
      else if (drop_c && (drop_cnt_q != '1))
        drop_cnt_q <= drop_cnt_q + TRACE_DROP_W'(1);
    end
  end

endmodule
